// File: rtl/fsm_trace_capture.sv
// Records a trace entry in a small FIFO each time the monitored FSM output triple changes.
// Optional per-entry cycle timestamps are built only when TRACE_TIMESTAMP_EN is defined.
module fsm_trace_capture #(
    parameter int DEPTH   = 8,
    parameter int STAMP_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     in_enable,
    input  logic [31:0]              in_value,
    input  logic                     in_flag,
    input  logic [3:0]               in_code,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [31:0]              rd_value,
    output logic                     rd_flag,
    output logic [3:0]               rd_code,
    output logic [STAMP_W-1:0]       rd_stamp,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int AW      = $clog2(DEPTH);
    localparam int ENTRY_W = 37;

    typedef enum logic {
        IDLE,
        ARMED
    } state_t;

    state_t               state, state_nxt;
    logic                 samp_en;
    logic [ENTRY_W-1:0]   samp_triple;
    logic [ENTRY_W-1:0]   last_triple;
    logic                 push_req;
    logic                 load_last;
    logic                 push;
    logic                 pop;
    logic                 empty;
    logic                 full;
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic [ENTRY_W-1:0]   mem [DEPTH];

    // Input sample stage: the triple is registered once before comparison.
    // NOTE: sequential state is always assigned with <= so every register sees pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            samp_en     <= 1'b0;
            samp_triple <= '0;
        end else if (clear) begin
            samp_en     <= 1'b0;
            samp_triple <= '0;
        end else begin
            samp_en     <= in_enable;
            samp_triple <= {in_value, in_flag, in_code};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else if (clear) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        push_req  = 1'b0;
        load_last = 1'b0;
        case (state)
            IDLE: begin
                if (samp_en) begin
                    push_req  = 1'b1;
                    load_last = 1'b1;
                    state_nxt = ARMED;
                end
            end
            ARMED: begin
                if (samp_en) begin
                    load_last = 1'b1;
                    push_req  = (samp_triple != last_triple);
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_triple <= '0;
        end else if (clear) begin
            last_triple <= '0;
        end else if (load_last) begin
            last_triple <= samp_triple;
        end
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = !clear && !empty && rd_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push  = !clear && push_req && (!full || pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push_req && full && !pop) overflow <= 1'b1;
        end
    end

    // NOTE: the entry storage has no reset; outputs are masked to 0 while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= samp_triple;
    end

    assign rd_valid = !empty;
    assign level    = wr_ptr - rd_ptr;
    assign {rd_value, rd_flag, rd_code} = empty ? '0 : mem[rd_ptr[AW-1:0]];

`ifdef TRACE_TIMESTAMP_EN
    logic [STAMP_W-1:0] stamp_cnt;
    logic [STAMP_W-1:0] stamp_mem [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stamp_cnt <= '0;
        end else if (clear) begin
            stamp_cnt <= '0;
        end else begin
            stamp_cnt <= stamp_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) stamp_mem[wr_ptr[AW-1:0]] <= stamp_cnt;
    end

    assign rd_stamp = empty ? '0 : stamp_mem[rd_ptr[AW-1:0]];
`else
    assign rd_stamp = '0;
`endif

endmodule

// File: tb/tb_fsm_trace_capture.sv
// Directed bench for fsm_trace_capture: table-driven capture sequence plus hand-written
// overflow, full-with-pop, re-enable and mid-drain reset sequences.
module tb_fsm_trace_capture;

    localparam int DEPTH   = 8;
    localparam int STAMP_W = 16;

    logic              clk;
    logic              reset;
    logic              clear;
    logic              in_enable;
    logic [31:0]       in_value;
    logic              in_flag;
    logic [3:0]        in_code;
    logic              rd_valid;
    logic              rd_ready;
    logic [31:0]       rd_value;
    logic              rd_flag;
    logic [3:0]        rd_code;
    logic [STAMP_W-1:0] rd_stamp;
    logic [3:0]        level;
    logic              overflow;

    int n_cmp  = 0;
    int n_fail = 0;

    fsm_trace_capture #(.DEPTH(DEPTH), .STAMP_W(STAMP_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .in_enable(in_enable),
        .in_value (in_value),
        .in_flag  (in_flag),
        .in_code  (in_code),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_value (rd_value),
        .rd_flag  (rd_flag),
        .rd_code  (rd_code),
        .rd_stamp (rd_stamp),
        .level    (level),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [31:0] value;
        logic        flag;
        logic [3:0]  code;
        logic [3:0]  exp_level;
        logic        exp_valid;
        logic [31:0] exp_value;
        logic        exp_flag;
        logic [3:0]  exp_code;
    } vec_t;

    vec_t vecs [12];

    function automatic vec_t mk(logic en, logic [31:0] v, logic f, logic [3:0] c,
                                logic [3:0] lvl, logic vld, logic [31:0] ev, logic ef,
                                logic [3:0] ec);
        vec_t r;
        r.en = en; r.value = v; r.flag = f; r.code = c;
        r.exp_level = lvl; r.exp_valid = vld;
        r.exp_value = ev; r.exp_flag = ef; r.exp_code = ec;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic check_head(input string name, input logic vld, input logic [31:0] v,
                              input logic f, input logic [3:0] c);
        check({name, "_valid"}, 64'(rd_valid), 64'(vld));
        check({name, "_entry"}, 64'({rd_value, rd_flag, rd_code}), 64'({v, f, c}));
`ifndef TRACE_TIMESTAMP_EN
        check({name, "_stamp0"}, 64'(rd_stamp), 64'd0);
`endif
    endtask

    logic [STAMP_W-1:0] stamps [3];
    logic [STAMP_W-1:0] d;

    initial begin
        reset = 1'b0; clear = 1'b0; in_enable = 1'b0;
        in_value = '0; in_flag = 1'b0; in_code = '0; rd_ready = 1'b0;

        vecs[0] = mk(1, 32'd0,  0, 4'd0, 4'd0, 0, 32'd0, 0, 4'd0);
        vecs[0].code = 4'd1;
        vecs[1] = mk(1, 32'd1,  1, 4'd1, 4'd1, 1, 32'd0, 0, 4'd1);
        vecs[2] = mk(1, 32'd15, 1, 4'd9, 4'd2, 1, 32'd0, 0, 4'd1);
        for (int i = 3; i < 12; i++)
            vecs[i] = mk(1, 32'd15, 1, 4'd9, 4'd3, 1, 32'd0, 0, 4'd1);

        repeat (2) step();
        check("rst_valid", 64'(rd_valid), 64'd0);
        check("rst_level", 64'(level), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_fields", 64'({rd_value, rd_flag, rd_code}), 64'd0);
        check("rst_stamp", 64'(rd_stamp), 64'd0);
        reset = 1'b1;
        step();
        check("post_rst_level", 64'(level), 64'd0);

        // Upstream sequence (0,0,1) -> (1,1,1) -> (15,1,9) held 10 cycles.
        for (int i = 0; i < 12; i++) begin
            in_enable = vecs[i].en;
            in_value  = vecs[i].value;
            in_flag   = vecs[i].flag;
            in_code   = vecs[i].code;
            step();
            check($sformatf("vec%0d_level", i), 64'(level), 64'(vecs[i].exp_level));
            check_head($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_value,
                       vecs[i].exp_flag, vecs[i].exp_code);
        end
        check("seq_overflow", 64'(overflow), 64'd0);

        check_head("drain0", 1, 32'd0, 0, 4'd1);
        stamps[0] = rd_stamp;
        rd_ready = 1'b1; step(); rd_ready = 1'b0;
        check_head("drain1", 1, 32'd1, 1, 4'd1);
        stamps[1] = rd_stamp;
        rd_ready = 1'b1; step(); rd_ready = 1'b0;
        check_head("drain2", 1, 32'd15, 1, 4'd9);
        stamps[2] = rd_stamp;
        rd_ready = 1'b1; step(); rd_ready = 1'b0;
        check("drain_done_valid", 64'(rd_valid), 64'd0);
        check("drain_done_level", 64'(level), 64'd0);
`ifdef TRACE_TIMESTAMP_EN
        d = stamps[1] - stamps[0];
        check("stamp_step01", 64'(d), 64'd1);
        d = stamps[2] - stamps[1];
        check("stamp_step12", 64'(d), 64'd1);
`endif

        // Constant triple held 20 cycles yields one entry.
        in_value = 32'h5; in_flag = 1'b1; in_code = 4'd3;
        do_clear();
        repeat (20) step();
        check("const_level", 64'(level), 64'd1);
        check_head("const_head", 1, 32'h5, 1, 4'd3);
        rd_ready = 1'b1; step(); rd_ready = 1'b0;
        check("const_pop_level", 64'(level), 64'd0);
        check("const_pop_valid", 64'(rd_valid), 64'd0);

        // Drop enable 3 cycles, re-enable with the same triple.
        in_enable = 1'b0;
        repeat (3) step();
        check("reen_off_level", 64'(level), 64'd0);
        in_enable = 1'b1;
        step();
        check("reen_sample_level", 64'(level), 64'd0);
        step();
        check("reen_level", 64'(level), 64'd1);
        check_head("reen_head", 1, 32'h5, 1, 4'd3);
        rd_ready = 1'b1; step(); rd_ready = 1'b0;

        // Overflow: 12 changing values with no reader.
        in_flag = 1'b0; in_code = 4'd0;
        do_clear();
        check("clr_overflow0", 64'(overflow), 64'd0);
        for (int i = 0; i < 12; i++) begin
            in_value = 32'h100 + 32'(i);
            step();
        end
        step();
        check("ovf_level", 64'(level), 64'd8);
        check("ovf_flag", 64'(overflow), 64'd1);
        rd_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check_head($sformatf("ovf_drain%0d", k), 1, 32'h100 + 32'(k), 0, 4'd0);
            step();
        end
        rd_ready = 1'b0;
        check("ovf_drained_valid", 64'(rd_valid), 64'd0);
        check("ovf_sticky", 64'(overflow), 64'd1);
        do_clear();
        check("ovf_cleared", 64'(overflow), 64'd0);

        // Full FIFO: push and pop on the same edge.
        for (int i = 0; i < 8; i++) begin
            in_value = 32'h200 + 32'(i);
            step();
        end
        step();
        check("full_level", 64'(level), 64'd8);
        check("full_overflow", 64'(overflow), 64'd0);
        in_value = 32'h208;
        step();
        check("full_sampled_level", 64'(level), 64'd8);
        rd_ready = 1'b1; step(); rd_ready = 1'b0;
        check("pushpop_level", 64'(level), 64'd8);
        check("pushpop_overflow", 64'(overflow), 64'd0);
        rd_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            check_head($sformatf("pp_drain%0d", k), 1, 32'h200 + 32'(k), 0, 4'd0);
            step();
        end
        rd_ready = 1'b0;
        check("pp_drained_valid", 64'(rd_valid), 64'd0);

        // Reset mid-drain with level=5 and overflow set.
        do_clear();
        for (int i = 0; i < 9; i++) begin
            in_value = 32'h300 + 32'(i);
            step();
        end
        step();
        check("mid_full_level", 64'(level), 64'd8);
        check("mid_full_ovf", 64'(overflow), 64'd1);
        rd_ready = 1'b1;
        repeat (3) step();
        check("mid_level5", 64'(level), 64'd5);
        check_head("mid_head", 1, 32'h303, 0, 4'd0);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_valid", 64'(rd_valid), 64'd0);
        check("mid_rst_level", 64'(level), 64'd0);
        check("mid_rst_overflow", 64'(overflow), 64'd0);
        check("mid_rst_fields", 64'({rd_value, rd_flag, rd_code}), 64'd0);
        rd_ready = 1'b0;
        #1;
        reset = 1'b1;
        step();
        check("post_mid_sample_level", 64'(level), 64'd0);
        step();
        check("post_mid_level", 64'(level), 64'd1);
        check_head("post_mid_head", 1, 32'h308, 0, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fsm_trace_capture.md
# fsm_trace_capture

Downstream consumer for a generated FSM unit-test block: watches the FSM's registered output triple (32-bit value, 1-bit flag, 4-bit code) every clock and records a trace entry each time the triple changes. Entries go into a small FIFO, optionally tagged with a cycle timestamp, and are drained by a bench reader or a host interface over a valid/ready handshake. This lets a bench check an FSM's output sequence without relying on simulator-only `$monitor` output.

## Interface
- DEPTH, 8, FIFO entries; must be a power of two, ≥2.
- STAMP_W, 16, timestamp width.
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 resets all state immediately.
- clear  in  1  synchronous flush; priority over all other actions.
- in_enable  in  1  capture enable.
- in_value  in  32  monitored value (upstream out1).
- in_flag  in  1  monitored flag (upstream out2).
- in_code  in  4  monitored code (upstream out3).
- rd_valid  out  1  head entry available.
- rd_ready  in  1  reader accepts the head entry.
- rd_value  out  32, rd_flag  out  1, rd_code  out  4  head entry fields.
- rd_stamp  out  STAMP_W  head entry timestamp.
- level  out  $clog2(DEPTH)+1  current entry count.
- overflow  out  1  sticky: a change was dropped because the FIFO was full.

## Operation
- States: IDLE, ARMED.
- IDLE, in_enable=1: push the current triple unconditionally, load the last-sample register, go to ARMED.
- IDLE, in_enable=0: no push; stay in IDLE.
- ARMED, in_enable=1: push if {in_value,in_flag,in_code} ≠ last-sample register. Load the last-sample register with the input every cycle, whether or not the push succeeds.
- ARMED, in_enable=0: no push; go to IDLE. Re-enabling always records the first sample.
- Pop: rd_valid && rd_ready removes the head entry.
- Full with push and no pop: drop the entry, set overflow=1. The last-sample register still updates.
- Full with push and pop in the same cycle: both proceed; level is unchanged; no overflow.
- Empty with push: entry visible the next cycle. No same-cycle bypass.
- Empty with rd_ready: no effect.
- Timestamp counter: STAMP_W bits, increments every cycle, wraps from all-ones to 0. Each entry records the counter value from its capture cycle.
- clear=1: empty the FIFO, level=0, overflow=0, state=IDLE, stamp counter=0. Pushes and pops in the same cycle are ignored.
- Pointers: $clog2(DEPTH)+1 bits; full/empty decided by the MSB compare.

## Timing
- Reset values: rd_valid=0, level=0, overflow=0, state=IDLE, stamp counter=0, last-sample register=0. rd_value, rd_flag, rd_code and rd_stamp read 0 while empty.
- Capture latency: an input change at edge N is sampled at edge N+1. The entry is on rd_* with rd_valid=1 after edge N+2 if the FIFO was empty.
- rd_* fields are stable while rd_valid=1 and rd_ready=0.
- level and overflow update on the same edge as the push or pop.
- A reset assertion mid-stream discards all entries at once. Capture after reset release starts from IDLE.

## Configuration
- TRACE_TIMESTAMP_EN defined: stamp counter and per-entry stamp storage are present; rd_stamp behaves as described.
- TRACE_TIMESTAMP_EN undefined: no counter and no stamp storage; rd_stamp is tied to 0. All other behaviour is identical.

## Test plan
- Upstream sequence: reset released, in_enable=1, triple (0,0,1), then (1,1,1), then (15,1,9) held 10 cycles, rd_ready=1 → exactly 3 entries in that order; stamps strictly increasing by 1 (TRACE_TIMESTAMP_EN).
- Hold a constant triple (0x5,1,3) for 20 cycles after enable → exactly 1 entry; level returns to 0 after the pop.
- DEPTH=8, rd_ready=0, toggle in_value every cycle for 12 cycles → level=8, overflow=1, first 8 values retained. Then set rd_ready=1 → those 8 drain in order; overflow stays 1 until clear.
- FIFO full, one new change arrives in the same cycle as a pop → level stays 8, new entry appended, overflow remains 0.
- Drop in_enable for 3 cycles, then re-enable with the triple unchanged → one new entry holding the same triple.
- Assert reset low mid-drain with level=5 → rd_valid=0, level=0, overflow=0 immediately. Without TRACE_TIMESTAMP_EN, rd_stamp=0 on every entry.
